// File: rtl/scene_sequencer_pkg.sv
// scene_sequencer_pkg: shared FSM state type and brightness constant
package scene_sequencer_pkg;
  typedef enum logic [1:0] {SHOW, FADE_OUT, SWITCH, FADE_IN} state_t;
  localparam logic [4:0] LEVEL_MAX = 5'd16;
endpackage

// File: rtl/scene_sequencer_if.sv
// scene_sequencer_if: timer/control/colour bundle between the video pipeline and the sequencer
interface scene_sequencer_if;
  logic [31:0] frame;
  logic        next_req;
  logic        pause;
  logic [3:0]  in_r, in_g, in_b;
  logic [1:0]  scene_sel;
  logic [3:0]  r, g, b;
  logic [4:0]  level;
  logic        fading;
  modport master (output frame, next_req, pause, in_r, in_g, in_b,
                  input scene_sel, r, g, b, level, fading);
  modport slave (input frame, next_req, pause, in_r, in_g, in_b,
                 output scene_sel, r, g, b, level, fading);
endinterface

// File: rtl/scene_sequencer_color_scaler.sv
// color_scaler: scales a 4-bit colour by a 0..16 brightness level
module color_scaler (
  input  logic [3:0] c,
  input  logic [4:0] level,
  output logic [3:0] y
);
  logic [8:0] p;
  assign p = 9'(c) * 9'(level);
  assign y = 4'(p >> 4);
endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: cycles scene generators with a fade-out/fade-in between scenes
module scene_sequencer
  import scene_sequencer_pkg::*;
#(
  parameter int SCENES           = 4,
  parameter int HOLD_FRAMES      = 600,
  parameter int FADE_STEP_FRAMES = 2
) (
  input logic clk,
  input logic rst,
  scene_sequencer_if.slave bus
);
  localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
  localparam int SW = $clog2(FADE_STEP_FRAMES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(FADE_STEP_FRAMES - 1);
  localparam logic [1:0] SEL_LAST = 2'(SCENES - 1);
  state_t state, state_n;
  logic [1:0] scene_sel, sel_n;
  logic [4:0] level, level_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [SW-1:0] step_cnt, step_n;
  logic pending, pend_n;
  logic [31:0] frame_prev;
  logic tick, step_done;
  assign tick = bus.frame != frame_prev;
  assign step_done = step_cnt == STEP_LAST;
  // state register; frame_prev resets to the timer's reset value so release makes no tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SHOW;
      scene_sel  <= '0;
      level      <= LEVEL_MAX;
      hold_cnt   <= '0;
      step_cnt   <= '0;
      pending    <= 1'b0;
      frame_prev <= '1;
    end else begin
      state      <= state_n;
      scene_sel  <= sel_n;
      level      <= level_n;
      hold_cnt   <= hold_n;
      step_cnt   <= step_n;
      pending    <= pend_n;
      frame_prev <= bus.frame;
    end
  end
  // next-state: skip requests latch any cycle in SHOW, everything else moves on frame ticks only
  always_comb begin
    state_n = state;
    sel_n   = scene_sel;
    level_n = level;
    hold_n  = hold_cnt;
    step_n  = step_cnt;
    pend_n  = pending | (state == SHOW && bus.next_req);
    if (tick) begin
      unique case (state)
        SHOW: begin
          if (pend_n || (!bus.pause && hold_cnt == HOLD_LAST)) begin
            state_n = FADE_OUT;
            hold_n  = '0;
            pend_n  = 1'b0;
          end else if (!bus.pause) hold_n = hold_cnt + 1'b1;
        end
        FADE_OUT: begin
          step_n = step_done ? '0 : step_cnt + 1'b1;
          if (step_done) begin
            level_n = level - 1'b1;
            state_n = level == 5'd1 ? SWITCH : FADE_OUT;
          end
        end
        SWITCH: begin
          sel_n   = scene_sel == SEL_LAST ? 2'd0 : scene_sel + 1'b1;
          step_n  = '0;
          state_n = FADE_IN;
        end
        FADE_IN: begin
          step_n = step_done ? '0 : step_cnt + 1'b1;
          if (step_done) begin
            level_n = level + 1'b1;
            if (level == LEVEL_MAX - 5'd1) begin
              state_n = SHOW;
              hold_n  = '0;
            end
          end
        end
      endcase
    end
  end
  assign bus.scene_sel = scene_sel;
  assign bus.level     = level;
  assign bus.fading    = state != SHOW;
  color_scaler u_r (.c(bus.in_r), .level(level), .y(bus.r));
  color_scaler u_g (.c(bus.in_g), .level(level), .y(bus.g));
  color_scaler u_b (.c(bus.in_b), .level(level), .y(bus.b));
endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed checks of hold, fade, wrap, skip, pause, scaling and reset
module tb_scene_sequencer;
  import scene_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  scene_sequencer_if bus ();
  scene_sequencer #(.SCENES(3), .HOLD_FRAMES(4), .FADE_STEP_FRAMES(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (10) @(negedge clk);
      bus.frame = bus.frame + 1;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_next();
    @(negedge clk) bus.next_req = 1'b1;
    @(negedge clk) bus.next_req = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.frame = '1;
    bus.pause = 1'b0;
    bus.next_req = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    bus.frame = '1;
    bus.next_req = 1'b0;
    bus.pause = 1'b0;
    bus.in_r = 4'd15;
    bus.in_g = 4'd8;
    bus.in_b = 4'd1;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(bus.level), 16);
    chk("rst_sel", 32'(bus.scene_sel), 0);
    chk("rst_fading", 32'(bus.fading), 0);
    chk("rst_r", 32'(bus.r), 15);
    chk("rst_g", 32'(bus.g), 8);
    chk("rst_b", 32'(bus.b), 1);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("release_no_tick", 32'(dut.hold_cnt), 0);
    tick(3);
    chk("t3_hold", 32'(dut.hold_cnt), 3);
    chk("t3_fading", 32'(bus.fading), 0);
    tick(1);
    chk("t4_state", 32'(dut.state), 32'(FADE_OUT));
    chk("t4_fading", 32'(bus.fading), 1);
    chk("t4_level", 32'(bus.level), 16);
    chk("t4_hold", 32'(dut.hold_cnt), 0);
    tick(1);
    chk("t5_level", 32'(bus.level), 15);
    tick(7);
    chk("t12_level", 32'(bus.level), 8);
    chk("l8_r", 32'(bus.r), 7);
    chk("l8_g", 32'(bus.g), 4);
    chk("l8_b", 32'(bus.b), 0);
    tick(8);
    chk("t20_level", 32'(bus.level), 0);
    chk("t20_state", 32'(dut.state), 32'(SWITCH));
    chk("t20_r", 32'(bus.r), 0);
    chk("t20_sel", 32'(bus.scene_sel), 0);
    tick(1);
    chk("t21_sel", 32'(bus.scene_sel), 1);
    chk("t21_state", 32'(dut.state), 32'(FADE_IN));
    chk("t21_level", 32'(bus.level), 0);
    tick(16);
    chk("t37_level", 32'(bus.level), 16);
    chk("t37_fading", 32'(bus.fading), 0);
    chk("t37_r", 32'(bus.r), 15);
    chk("t37_g", 32'(bus.g), 8);
    chk("t37_b", 32'(bus.b), 1);
    tick(37);
    chk("wrap_sel2", 32'(bus.scene_sel), 2);
    chk("wrap_fading2", 32'(bus.fading), 0);
    tick(37);
    chk("wrap_sel0", 32'(bus.scene_sel), 0);
    chk("wrap_fading0", 32'(bus.fading), 0);
    bus.pause = 1'b1;
    tick(10);
    chk("pause_hold", 32'(dut.hold_cnt), 0);
    chk("pause_fading", 32'(bus.fading), 0);
    bus.pause = 1'b0;
    tick(3);
    chk("unpause_hold", 32'(dut.hold_cnt), 3);
    chk("unpause_fading3", 32'(bus.fading), 0);
    tick(1);
    chk("unpause_fading4", 32'(bus.fading), 1);
    tick(33);
    chk("pause_cycle_sel", 32'(bus.scene_sel), 1);
    chk("pause_cycle_fading", 32'(bus.fading), 0);
    bus.pause = 1'b1;
    tick(1);
    pulse_next();
    chk("skip_latched", 32'(dut.pending), 1);
    chk("skip_wait_tick", 32'(bus.fading), 0);
    tick(1);
    chk("skip_state", 32'(dut.state), 32'(FADE_OUT));
    chk("skip_pending_clr", 32'(dut.pending), 0);
    chk("skip_level", 32'(bus.level), 16);
    tick(3);
    chk("skip_pause_ignored", 32'(bus.level), 13);
    pulse_next();
    chk("fade_req_ignored", 32'(dut.pending), 0);
    tick(13);
    chk("skip_switch", 32'(dut.state), 32'(SWITCH));
    tick(1);
    chk("skip_sel", 32'(bus.scene_sel), 2);
    tick(16);
    chk("skip_done_level", 32'(bus.level), 16);
    chk("skip_done_fading", 32'(bus.fading), 0);
    tick(1);
    chk("no_stale_skip", 32'(bus.fading), 0);
    chk("no_stale_hold", 32'(dut.hold_cnt), 0);
    do_reset();
    tick(30);
    chk("mid_level", 32'(bus.level), 9);
    chk("mid_sel", 32'(bus.scene_sel), 1);
    chk("mid_fading", 32'(bus.fading), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    bus.frame = '1;
    #1;
    chk("async_level", 32'(bus.level), 16);
    chk("async_sel", 32'(bus.scene_sel), 0);
    chk("async_fading", 32'(bus.fading), 0);
    chk("async_r", 32'(bus.r), 15);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rerelease_hold", 32'(dut.hold_cnt), 0);
    chk("rerelease_fading", 32'(bus.fading), 0);
    tick(1);
    chk("rerelease_t1_hold", 32'(dut.hold_cnt), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
